// File: rtl/seg7_scan_capture.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_capture
//  Purpose  : Receive-side monitor for a 4-digit multiplexed seven-segment
//             bus. Each digit slot is captured once it has settled, and its
//             glyph is decoded back to a hex nibble. A complete 16-bit word
//             is published once all four slots have been seen.
//  Ports    : clk          system clock, rising edge
//             reset        asynchronous, active-high reset
//             segments     active-low glyph {A,B,C,D,E,F,G} (bit 6 = A)
//             anodes       active-low digit select (bit 0 = rightmost)
//             value        last complete frame, nibble k from anode k
//             frame_valid  one-cycle pulse when value updates
//             digit_err    one-cycle pulse on undecodable settled glyph
//             err_count    saturating digit_err counter (optional)
//  Options  : SEG7_CAP_ERRCNT_EN - adds err_count output and counter
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_capture #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  segments,
    input  logic [3:0]  anodes,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic        digit_err
`ifdef SEG7_CAP_ERRCNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    localparam logic [7:0] c_cnt_sat = 8'(SETTLE_CYCLES);
    localparam logic [7:0] c_cnt_cap = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_SCAN = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t      r_state;
    logic [10:0] r_smp;
    logic [7:0]  r_cnt;
    logic [3:0]  r_seen;
    logic [15:0] r_shadow;

    logic [10:0] w_in;
    logic        w_same;
    logic        w_capture;
    logic        w_slot_ok;
    logic [1:0]  w_slot;
    logic        w_glyph_ok;
    logic [3:0]  w_nib;
    logic [3:0]  w_seen_next;
    logic [15:0] w_shadow_next;
    logic        w_accept;
    logic        w_reject;

    // Returns {valid, nibble} for an active-low glyph.
    function automatic logic [4:0] decode_glyph(input logic [6:0] g);
        logic [4:0] r;
        case (g)
            7'h01:   r = {1'b1, 4'h0};
            7'h4F:   r = {1'b1, 4'h1};
            7'h12:   r = {1'b1, 4'h2};
            7'h06:   r = {1'b1, 4'h3};
            7'h4C:   r = {1'b1, 4'h4};
            7'h24:   r = {1'b1, 4'h5};
            7'h20:   r = {1'b1, 4'h6};
            7'h0F:   r = {1'b1, 4'h7};
            7'h00:   r = {1'b1, 4'h8};
            7'h04:   r = {1'b1, 4'h9};
            7'h08:   r = {1'b1, 4'hA};
            7'h60:   r = {1'b1, 4'hB};
            7'h31:   r = {1'b1, 4'hC};
            7'h42:   r = {1'b1, 4'hD};
            7'h30:   r = {1'b1, 4'hE};
            7'h38:   r = {1'b1, 4'hF};
            default: r = 5'b0_0000;
        endcase
        return r;
    endfunction

    assign w_in = {anodes, segments};

    // Comparing the incoming word against smp is the same as asking whether
    // smp is about to differ from its previous value, so the counter clears
    // on the very edge the sample changes. This puts the capture event at
    // edge t+SETTLE_CYCLES for inputs first sampled at edge t.
    assign w_same    = (w_in == r_smp);
    assign w_capture = (r_state == ST_SCAN) && w_same && (r_cnt == c_cnt_cap);

    always_comb begin
        w_slot_ok = 1'b0;
        w_slot    = 2'd0;
        case (r_smp[10:7])
            4'b1110: begin w_slot_ok = 1'b1; w_slot = 2'd0; end
            4'b1101: begin w_slot_ok = 1'b1; w_slot = 2'd1; end
            4'b1011: begin w_slot_ok = 1'b1; w_slot = 2'd2; end
            4'b0111: begin w_slot_ok = 1'b1; w_slot = 2'd3; end
            default: begin w_slot_ok = 1'b0; w_slot = 2'd0; end
        endcase
        {w_glyph_ok, w_nib} = decode_glyph(r_smp[6:0]);
        w_seen_next   = r_seen | (4'b0001 << w_slot);
        w_shadow_next = r_shadow;
        w_shadow_next[{w_slot, 2'b00} +: 4] = w_nib;
        w_accept = w_capture && w_slot_ok && w_glyph_ok;
        w_reject = w_capture && w_slot_ok && !w_glyph_ok;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_SCAN;
            r_smp       <= 11'h000;
            r_cnt       <= 8'd0;
            r_seen      <= 4'h0;
            r_shadow    <= 16'h0000;
            value       <= 16'h0000;
            frame_valid <= 1'b0;
            digit_err   <= 1'b0;
`ifdef SEG7_CAP_ERRCNT_EN
            err_count   <= 8'd0;
`endif
        end else begin
            r_smp       <= w_in;
            frame_valid <= 1'b0;
            digit_err   <= 1'b0;

            if (!w_same) begin
                r_cnt <= 8'd0;
            end else if (r_cnt < c_cnt_sat) begin
                r_cnt <= r_cnt + 8'd1;
            end

            // HOLD guarantees a long dwell is evaluated only once.
            case (r_state)
                ST_SCAN: if (w_capture) r_state <= ST_HOLD;
                ST_HOLD: if (!w_same)   r_state <= ST_SCAN;
                default: r_state <= ST_SCAN;
            endcase

            if (w_accept) begin
                r_shadow <= w_shadow_next;
                if (w_seen_next == 4'hF) begin
                    value       <= w_shadow_next;
                    frame_valid <= 1'b1;
                    r_seen      <= 4'h0;
                end else begin
                    r_seen      <= w_seen_next;
                end
            end

            if (w_reject) begin
                digit_err <= 1'b1;
            end

`ifdef SEG7_CAP_ERRCNT_EN
            if (w_reject && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_capture
//  Purpose  : Self-checking bench for seg7_scan_capture. Expected frames are
//             queued when the completing digit is driven and compared when
//             frame_valid fires.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  segments = 7'h7F;
    logic [3:0]  anodes = 4'hF;
    logic [15:0] value;
    logic        frame_valid;
    logic        digit_err;
`ifdef SEG7_CAP_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_frames = 0;
    int n_derr   = 0;

    logic [15:0] exp_q[$];
    logic [6:0]  glyph [16];

    seg7_scan_capture #(.SETTLE_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .segments    (segments),
        .anodes      (anodes),
        .value       (value),
        .frame_valid (frame_valid),
        .digit_err   (digit_err)
`ifdef SEG7_CAP_ERRCNT_EN
        ,
        .err_count   (err_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        glyph[0]  = 7'h01; glyph[1]  = 7'h4F; glyph[2]  = 7'h12; glyph[3]  = 7'h06;
        glyph[4]  = 7'h4C; glyph[5]  = 7'h24; glyph[6]  = 7'h20; glyph[7]  = 7'h0F;
        glyph[8]  = 7'h00; glyph[9]  = 7'h04; glyph[10] = 7'h08; glyph[11] = 7'h60;
        glyph[12] = 7'h31; glyph[13] = 7'h42; glyph[14] = 7'h30; glyph[15] = 7'h38;
    end

    // Scoreboard: every frame_valid pops one expected word.
    always @(negedge clk) begin
        if (!reset) begin
            if (digit_err) n_derr++;
            if (frame_valid) begin
                n_frames++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL frame_unexpected: got value=%h, no frame expected", value);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if (value !== e) begin
                        n_errors++;
                        $display("FAIL frame_value: got %h, expected %h", value, e);
                    end
                end
            end
        end
    end

    task automatic show_raw(input logic [3:0] an, input logic [6:0] sg, input int cycles);
        anodes   = an;
        segments = sg;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic show(input int k, input int nib, input int cycles);
        show_raw(~(4'b0001 << k), glyph[nib], cycles);
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks += 3;
        if (value !== 16'h0000) begin n_errors++; $display("FAIL reset_value: got %h, expected 0000", value); end
        if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL reset_fv: got %b, expected 0", frame_valid); end
        if (digit_err !== 1'b0) begin n_errors++; $display("FAIL reset_derr: got %b, expected 0", digit_err); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clean_frame;
        int e0;
        e0 = n_derr;
        show(3, 1, 8);
        show(2, 2, 8);
        show(1, 3, 8);
        exp_q.push_back(16'h1234);
        show(0, 4, 4);
        n_checks++;
        if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL clean_fv_early: got %b, expected 0", frame_valid); end
        @(negedge clk);
        n_checks++;
        if (frame_valid !== 1'b1) begin n_errors++; $display("FAIL clean_fv_latency: got %b, expected 1", frame_valid); end
        @(negedge clk);
        n_checks++;
        if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL clean_fv_width: got %b, expected 0", frame_valid); end
        repeat (3) @(negedge clk);
        chk_int("clean_no_derr", n_derr - e0, 0);
    endtask

    task automatic test_glitch;
        int e0, f0;
        e0 = n_derr; f0 = n_frames;
        show(3, 10, 8);
        show(2, 11, 2);
        show_raw(4'b1011, 7'h7E, 3);
        show(2, 11, 8);
        show(1, 12, 8);
        exp_q.push_back(16'hABCD);
        show(0, 13, 8);
        chk_int("glitch_no_derr", n_derr - e0, 0);
        chk_int("glitch_frames", n_frames - f0, 1);
    endtask

    task automatic test_long_dwell;
        int f0;
        f0 = n_frames;
        show(0, 8, 100);
        show(1, 0, 8);
        show(2, 0, 8);
        exp_q.push_back(16'h0008);
        show(3, 0, 8);
        chk_int("dwell_frames", n_frames - f0, 1);
    endtask

    task automatic test_bad_glyph;
        int e0, f0;
        e0 = n_derr; f0 = n_frames;
        show(3, 1, 8);
        show(2, 2, 8);
        show_raw(4'b1101, 7'h7F, 10);
        show(0, 3, 8);
        chk_int("bad_derr_pulses", n_derr - e0, 1);
        chk_int("bad_no_frame", n_frames - f0, 0);
        exp_q.push_back(16'h1243);
        show(1, 4, 8);
        chk_int("bad_frame_after_fix", n_frames - f0, 1);
`ifdef SEG7_CAP_ERRCNT_EN
        chk_int("err_count", int'(err_count), 1);
`endif
    endtask

    task automatic test_blank_ghost;
        int e0, f0;
        e0 = n_derr; f0 = n_frames;
        show_raw(4'hF, 7'h01, 20);
        show_raw(4'b0101, 7'h7F, 20);
        show_raw(4'b0101, 7'h04, 20);
        show(3, 9, 8);
        show(2, 9, 8);
        show(1, 9, 8);
        chk_int("blank_no_derr", n_derr - e0, 0);
        chk_int("blank_no_frame", n_frames - f0, 0);
        exp_q.push_back(16'h9999);
        show(0, 9, 8);
        chk_int("blank_frame", n_frames - f0, 1);
    endtask

    task automatic test_reset_mid_frame;
        int f0;
        show(3, 5, 8);
        show(2, 6, 8);
        #2 reset = 1'b1;
        #1;
        n_checks += 2;
        if (value !== 16'h0000) begin n_errors++; $display("FAIL midreset_value: got %h, expected 0000", value); end
        if (frame_valid !== 1'b0) begin n_errors++; $display("FAIL midreset_fv: got %b, expected 0", frame_valid); end
        @(negedge clk);
        reset = 1'b0;
        f0 = n_frames;
        show(3, 5, 8);
        show(2, 6, 8);
        show(1, 7, 8);
        exp_q.push_back(16'h5678);
        show(0, 8, 8);
        chk_int("midreset_frames", n_frames - f0, 1);
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_glitch();
        test_long_dwell();
        test_bad_glyph();
        test_blank_ghost();
        test_reset_mid_frame();
        show_raw(4'hF, 7'h7F, 10);
        chk_int("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_capture.md
# seg7_scan_capture

Receive-side counterpart of the 4-digit multiplexed seven-segment driver. It watches the active-low `segments`/`anodes` bus and waits for each digit slot to settle. It then decodes each glyph back to a hex nibble and publishes a complete 16-bit word once all four digits have been seen. It is used for on-chip loopback checking of the display path and as a self-checking monitor in benches.

## Interface
- `SETTLE_CYCLES`, default 4: consecutive identical samples required before a digit is accepted. Legal range is 2..255.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  **asynchronous, active-high** reset.
- `segments`  in  7  active-low glyph, bit order {A,B,C,D,E,F,G}. Bit 6 is A.
- `anodes`  in  4  active-low digit select. Bit 0 selects the rightmost digit.
- `value`  out  16  last complete frame. Nibble k comes from anode k (`value[3:0]` is anode 0).
- `frame_valid`  out  1  one-cycle pulse when `value` updates.
- `digit_err`  out  1  one-cycle pulse when a settled, one-hot slot shows an undecodable glyph.

## Operation
- **Input sampling:** `{anodes,segments}` is registered once into `smp`. All logic below works on `smp`.
- **Stability counter `cnt`** (8-bit):
  - Cleared when `smp` differs from its previous value.
  - Otherwise incremented, saturating at `SETTLE_CYCLES`.
- **FSM states:**
  - SCAN → HOLD when `cnt` reaches `SETTLE_CYCLES-1` on an unchanged sample. This is the capture event.
  - HOLD → SCAN on any change of `smp`.
  - Consequence: a slot held for a long time is evaluated exactly once.
- **On a capture event:**
  - If `anodes` is not exactly one bit low (blanking 4'hF, ghosting, multiple low), ignore it. No error is flagged.
  - Otherwise decode `segments` (hex, active-low) as follows:
    - 0=7'h01, 1=4F, 2=12, 3=06
    - 4=4C, 5=24, 6=20, 7=0F
    - 8=00, 9=04, A=08, b=60
    - C=31, d=42, E=30, F=38
  - Match: write the nibble into shadow register slot k and set `seen[k]`. A repeat capture of slot k overwrites the nibble; `seen` is unchanged.
  - No match: pulse `digit_err`. `seen` and shadow are untouched.
- **Frame completion:** when `seen` becomes 4'hF:
  - `value` ← shadow.
  - `frame_valid` pulses.
  - `seen` clears.
- **Reset (asynchronous, any time):**
  - Clears `smp`, `cnt`, `seen`, shadow and FSM (to SCAN).
  - Reset values: `value`=16'h0000, `frame_valid`=0, `digit_err`=0.
  - A partial frame in progress is discarded.
  - The first `smp` after reset is compared against the reset value 11'h000.

## Timing
- **Capture latency:** inputs presented before edge t are in `smp` after edge t. The capture event occurs at edge t+`SETTLE_CYCLES`, provided inputs are held through it.
- **Error latency:** `digit_err` is high for exactly the cycle after the capture edge.
- **Frame latency:** `frame_valid` and the new `value` appear the cycle after the capture edge of the fourth distinct slot. `value` is stable until the next frame.
- **Glitch rejection:** a change at or before edge t+`SETTLE_CYCLES` restarts counting. Glitches shorter than `SETTLE_CYCLES` cycles are never captured.
- **Mid-stream start:** a digit dwell that starts mid-settle after reset is simply counted from the first sample.
- **Simultaneous events:** a capture completing the frame and a new input change in the same cycle are both honoured. The frame publishes and the counter restarts.
- **Throughput:** no backpressure. Frames complete as fast as the driver scans.

## Configuration
- **`SEG7_CAP_ERRCNT_EN` defined:** adds output `err_count` [7:0].
  - Reset 0.
  - Increments on every `digit_err` pulse, saturating at 8'hFF.
  - Cleared only by `reset`.
- **Undefined:** the port and counter are absent. All other behaviour is identical.

## Test plan
- **Clean frame:** drive digits 1,2,3,4 (anode 3..0), each dwell 8 cycles, `SETTLE_CYCLES`=4.
  - `value`=16'h1234.
  - Single-cycle `frame_valid` 1 cycle after anode-0 capture.
  - No `digit_err`.
- **Glitch rejection:** insert a 3-cycle glitch `segments`=7'h7E on anode 2 of frame A,B,C,D.
  - No `digit_err`.
  - `value`=16'hABCD.
- **Long dwell:** hold anode 0 with glyph 7'h00 for 100 cycles, then scan the remaining slots with 0.
  - One capture only.
  - `value`=16'h0008.
- **Bad glyph:** `segments`=7'h7F on anode 1 for 10 cycles.
  - One `digit_err` pulse.
  - No `frame_valid` until anode 1 later shows a valid glyph.
  - With `SEG7_CAP_ERRCNT_EN`: `err_count`=1.
- **Blanking/ghosting:** `anodes`=4'hF and 4'b0101 held 20 cycles.
  - No capture, no error.
- **Reset mid-frame:** pulse `reset` after 2 of 4 digits.
  - Outputs are 0 immediately.
  - The next full scan 5,6,7,8 yields exactly one `frame_valid` with 16'h5678.
